alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit; companion to the combinational ALU in the MIPS core.
- Supports signed and unsigned MULT/DIV on WIDTH-bit operands and holds the results in architectural HI/LO registers.
- Uses a start/busy/done handshake so the pipeline can stall, a cancel input for exception flush, and direct HI/LO writes for MTHI/MTLO.
- Iterative radix-2 datapath: shift-add for multiply, restoring division for divide.

Parameters:
- WIDTH, 32, operand, HI and LO width (>=4, even).
- CNT_WIDTH, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  launch the op on op_sel/op_a/op_b; accepted only in IDLE.
- op_sel  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  in  WIDTH  multiplicand / dividend.
- op_b  in  WIDTH  multiplier / divisor.
- cancel  in  1  abort the in-flight op.
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wr_data  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  op in flight; pipeline stalls on MFHI/MFLO/new op.
- done  out  1  one-cycle pulse when HI/LO are updated by an op.
- hi  out  WIDTH  HI register: product upper half / remainder.
- lo  out  WIDTH  LO register: product lower half / quotient.
- div_zero_flag  out  1  set on done of a DIV/DIVU with op_b==0; cleared on the next accepted start.
- zero_flag  out  1  registered; 1 when {hi,lo}==0 after the last update.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; hi=0; lo=0; div_zero_flag=0; zero_flag=1; counter=0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE with start=1:
  - Latch operands as magnitudes: two's-complement abs if the op is signed and the operand MSB is 1.
  - Latch result-sign bits.
  - counter=WIDTH; busy=1 from the same edge; next state CALC.
- Divide-by-zero: in IDLE, start with DIV/DIVU and op_b==0 goes directly to FIX.
  - hi/lo are left unchanged; div_zero_flag=1; done pulses at the FIX exit edge.
  - Total latency is 2 edges.
- CALC: one iteration per cycle; counter decrements; leave for FIX when counter reaches 1 on that edge. Exactly WIDTH cycles.
  - MUL: if multiplier LSB==1, add the multiplicand to the upper accumulator (WIDTH+1 bits, carry kept); then shift {acc,mplr} right 1.
  - DIV: shift {rem,quot} left 1; trial = rem - divisor on WIDTH+1 bits; if non-negative, rem=trial and quot LSB=1.
- FIX (1 cycle): apply sign correction, write hi/lo, set done=1 and busy=0 on the exit edge.
  - MULT: negate the 2*WIDTH-bit product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
- Latency: start edge E0; hi/lo are valid and done=1 after edge E0+WIDTH+1. busy is high for WIDTH+1 cycles.
- Signed MIN / -1: lo=MIN (wraps), hi=0; no flag raised.
- start while busy: ignored; no queueing.
- cancel: in CALC or FIX, go to IDLE next edge.
  - hi/lo unchanged; no done pulse; div_zero_flag unchanged.
  - cancel and start together in IDLE: cancel wins, op not accepted.
- wr_hi/wr_lo in IDLE: update on that edge; zero_flag is recomputed from the new values.
  - Ignored while busy.
  - start and a write in the same IDLE cycle: start wins, write dropped.
- zero_flag: registered; recomputed whenever hi or lo is written (FIX exit or MTHI/MTLO).

Decomposition:
- Shared defines (alongside the existing ALU defines): MD_OP_MULT/MULTU/DIV/DIVU encodings, MD_OPSEL_WIDTH=2, state encodings.
- One natural sub-module: md_sign_fix. Combinational abs on entry and conditional negate on exit, parametrised by WIDTH; instantiated for operands and results.
- FSM, counter and iteration datapath stay in the top module.

Test Plan:
- Reset mid-CALC of MULTU -> busy=0, hi=lo=0, no done pulse, zero_flag=1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy was high exactly 33 cycles.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> done after 2 edges, div_zero_flag=1, hi/lo keep prior values.
- start while busy with new operands -> ignored, first result intact. cancel at CALC cycle 10 -> no done, hi/lo unchanged.
- MTLO 0 and MTHI 0 in IDLE -> zero_flag=1. MTLO 0x1234 -> lo=0x1234, zero_flag=0. MTHI during busy -> hi unchanged. start+wr_lo in the same IDLE cycle -> op runs, write dropped.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package alu_muldiv_seq_pkg;

    localparam int MD_OPSEL_WIDTH = 2;

    typedef enum logic [MD_OPSEL_WIDTH-1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_sign_fix.sv
// Conditional two's-complement negate: abs of operands on entry,
// sign restore of results on exit.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Negating the most-negative value wraps back to itself, which is what
    // both the abs path and the MIN / -1 quotient want.
    always_comb begin
        result = negate ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle radix-2 multiply/divide unit with architectural HI/LO.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; MTHI/MTLO writes accepted here
// CALC    | one shift-add / restoring-divide iteration per cycle
// FIX     | sign correction and HI/LO write (or divide-by-zero report)
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MD_OPSEL_WIDTH-1:0] op_sel,
    input  logic [WIDTH-1:0]          op_a,
    input  logic [WIDTH-1:0]          op_b,
    input  logic                      cancel,
    input  logic                      wr_hi,
    input  logic                      wr_lo,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          hi,
    output logic [WIDTH-1:0]          lo,
    output logic                      div_zero_flag,
    output logic                      zero_flag
);

    md_state_e          state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    // mcand_q: multiplicand or divisor magnitude
    // acc_q:   product upper half (with carry) or partial remainder
    // mplr_q:  multiplier being shifted out, or dividend/quotient
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   mplr_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               is_div_q;
    logic               dz_q;

    md_op_e             op_e;
    logic               op_signed;
    logic               op_div;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;

    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quot_res;
    logic [WIDTH-1:0]   rem_res;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   mt_hi;
    logic [WIDTH-1:0]   mt_lo;

    // Decode the requested operation and operand signs.
    always_comb begin
        op_e      = md_op_e'(op_sel);
        op_signed = is_signed_op(op_e);
        op_div    = is_div_op(op_e);
        neg_a     = op_signed & op_a[WIDTH-1];
        neg_b     = op_signed & op_b[WIDTH-1];
    end

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .value  (op_a),
        .negate (neg_a),
        .result (abs_a)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .value  (op_b),
        .negate (neg_b),
        .result (abs_b)
    );

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value  ({acc_q[WIDTH-1:0], mplr_q}),
        .negate (sign_a_q ^ sign_b_q),
        .result (prod_res)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
        .value  (mplr_q),
        .negate (sign_a_q ^ sign_b_q),
        .result (quot_res)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc_q[WIDTH-1:0]),
        .negate (sign_a_q),
        .result (rem_res)
    );

    // One iteration step for each datapath, plus the values HI/LO would take.
    always_comb begin
        mul_sum   = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_q[WIDTH-1:0], mplr_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        fix_hi    = is_div_q ? rem_res  : prod_res[2*WIDTH-1:WIDTH];
        fix_lo    = is_div_q ? quot_res : prod_res[WIDTH-1:0];
        mt_hi     = wr_hi ? wr_data : hi;
        mt_lo     = wr_lo ? wr_data : lo;
    end

    // Sequencer, iteration datapath and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mcand_q       <= '0;
            acc_q         <= '0;
            mplr_q        <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            is_div_q      <= 1'b0;
            dz_q          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hi            <= '0;
            lo            <= '0;
            div_zero_flag <= 1'b0;
            zero_flag     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        mcand_q       <= op_div ? abs_b : abs_a;
                        mplr_q        <= op_div ? abs_a : abs_b;
                        acc_q         <= '0;
                        sign_a_q      <= neg_a;
                        sign_b_q      <= neg_b;
                        is_div_q      <= op_div;
                        dz_q          <= op_div && (op_b == '0);
                        cnt_q         <= CNT_WIDTH'(WIDTH);
                        busy          <= 1'b1;
                        div_zero_flag <= 1'b0;
                        state_q       <= (op_div && (op_b == '0)) ? ST_FIX : ST_CALC;
                    end else if (wr_hi || wr_lo) begin
                        hi        <= mt_hi;
                        lo        <= mt_lo;
                        zero_flag <= (mt_hi == '0) && (mt_lo == '0);
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        if (is_div_q) begin
                            if (!div_trial[WIDTH]) begin
                                acc_q  <= div_trial;
                                mplr_q <= {mplr_q[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_q  <= div_shift;
                                mplr_q <= {mplr_q[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_q  <= {1'b0, mul_sum[WIDTH:1]};
                            mplr_q <= {mul_sum[0], mplr_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (!cancel) begin
                        if (dz_q) begin
                            div_zero_flag <= 1'b1;
                        end else begin
                            hi        <= fix_hi;
                            lo        <= fix_lo;
                            zero_flag <= (fix_hi == '0) && (fix_lo == '0);
                        end
                        done <= 1'b1;
                    end
                    busy    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq (WIDTH=32).
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op_sel;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          cancel;
    logic          wr_hi;
    logic          wr_lo;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_zero_flag;
    logic          zero_flag;

    int vectors     = 0;
    int miscompares = 0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op_sel        (op_sel),
        .op_a          (op_a),
        .op_b          (op_b),
        .cancel        (cancel),
        .wr_hi         (wr_hi),
        .wr_lo         (wr_lo),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .hi            (hi),
        .lo            (lo),
        .div_zero_flag (div_zero_flag),
        .zero_flag     (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        op_sel = sel;
        op_a   = a;
        op_b   = b;
        cycle();
        start  = 1'b0;
    endtask

    // Called just after the start edge; counts edges until done and busy cycles.
    task automatic wait_done(input string tag, input int exp_edges, input bit chk_lat);
        int n;
        int busy_n;
        n      = 0;
        busy_n = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 100) begin
            cycle();
            n++;
            if (busy === 1'b1) busy_n++;
        end
        check({tag, " done"}, {63'b0, done}, 64'd1);
        if (chk_lat) begin
            check({tag, " latency"}, 64'(n), 64'(exp_edges));
            check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_edges));
        end
    endtask

    task automatic check_hilo(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
        check({tag, " hi"}, {32'b0, hi}, {32'b0, eh});
        check({tag, " lo"}, {32'b0, lo}, {32'b0, el});
    endtask

    initial begin
        int seen_done;
        rst     = 1'b1;
        start   = 1'b0;
        op_sel  = 2'b00;
        op_a    = '0;
        op_b    = '0;
        cancel  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = '0;
        cycle();
        cycle();
        check("rst busy", {63'b0, busy}, 64'd0);
        check("rst done", {63'b0, done}, 64'd0);
        check_hilo("rst", 32'h0, 32'h0);
        check("rst dzf", {63'b0, div_zero_flag}, 64'd0);
        check("rst zf", {63'b0, zero_flag}, 64'd1);
        rst = 1'b0;
        cycle();

        // Load nonzero LO, then reset in the middle of a MULTU.
        wr_lo = 1'b1; wr_data = 32'h55; cycle(); wr_lo = 1'b0;
        check("mtlo55 lo", {32'b0, lo}, 64'h55);
        issue(2'b01, 32'd3, 32'd5);
        repeat (5) cycle();
        check("midcalc busy", {63'b0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst busy", {63'b0, busy}, 64'd0);
        check_hilo("arst", 32'h0, 32'h0);
        check("arst zf", {63'b0, zero_flag}, 64'd1);
        cycle();
        rst = 1'b0;
        seen_done = 0;
        repeat (40) begin
            cycle();
            if (done === 1'b1) seen_done++;
        end
        check("arst no_done", 64'(seen_done), 64'd0);
        check("arst busy_after", {63'b0, busy}, 64'd0);

        // MULTU max * max
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 33, 1'b1);
        check_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        check("multu_max zf", {63'b0, zero_flag}, 64'd0);
        cycle();
        check("multu_max done_pulse", {63'b0, done}, 64'd0);

        // MULT -3 * 5
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg", 33, 1'b1);
        check_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // DIV -7 / 2
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 33, 1'b1);
        check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV 7 / -2 : quotient -3, remainder +1
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_negb", 33, 1'b0);
        check_hilo("div_negb", 32'h0000_0001, 32'hFFFF_FFFD);

        // DIVU 100 / 7
        issue(2'b11, 32'd100, 32'd7);
        wait_done("divu", 33, 1'b1);
        check_hilo("divu", 32'h0000_0002, 32'h0000_000E);

        // DIV MIN / -1 wraps
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min", 33, 1'b1);
        check_hilo("div_min", 32'h0, 32'h8000_0000);
        check("div_min dzf", {63'b0, div_zero_flag}, 64'd0);
        check("div_min zf", {63'b0, zero_flag}, 64'd0);

        // DIVU 5 / 0
        issue(2'b11, 32'd5, 32'd0);
        wait_done("divu_zero", 1, 1'b1);
        check_hilo("divu_zero", 32'h0, 32'h8000_0000);
        check("divu_zero dzf", {63'b0, div_zero_flag}, 64'd1);

        // start while busy is ignored
        issue(2'b01, 32'd6, 32'd7);
        check("dzf cleared", {63'b0, div_zero_flag}, 64'd0);
        repeat (2) cycle();
        start = 1'b1; op_sel = 2'b11; op_a = 32'd100; op_b = 32'd7;
        repeat (3) cycle();
        start = 1'b0;
        wait_done("busy_start", 33, 1'b0);
        check_hilo("busy_start", 32'h0, 32'd42);
        cycle();
        check("busy_start no_requeue", {63'b0, busy}, 64'd0);

        // cancel at CALC cycle 10
        issue(2'b01, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (9) cycle();
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        check("cancel busy", {63'b0, busy}, 64'd0);
        seen_done = 0;
        repeat (40) begin
            if (done === 1'b1) seen_done++;
            cycle();
        end
        check("cancel no_done", 64'(seen_done), 64'd0);
        check_hilo("cancel", 32'h0, 32'd42);

        // cancel + start in IDLE: not accepted
        cancel = 1'b1;
        issue(2'b01, 32'd2, 32'd2);
        cancel = 1'b0;
        check("cancel_start busy", {63'b0, busy}, 64'd0);

        // MTHI/MTLO zero -> zero_flag
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0;
        cycle();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check_hilo("mt_zero", 32'h0, 32'h0);
        check("mt_zero zf", {63'b0, zero_flag}, 64'd1);

        wr_lo = 1'b1; wr_data = 32'h1234;
        cycle();
        wr_lo = 1'b0;
        check_hilo("mtlo", 32'h0, 32'h1234);
        check("mtlo zf", {63'b0, zero_flag}, 64'd0);

        // MTHI while busy is ignored
        issue(2'b01, 32'd2, 32'd3);
        wr_hi = 1'b1; wr_data = 32'hDEAD;
        cycle();
        wr_hi = 1'b0;
        check("mthi_busy hi", {32'b0, hi}, 64'h0);
        wait_done("mthi_busy", 33, 1'b0);
        check_hilo("mthi_busy", 32'h0, 32'd6);

        // start and MTLO together: start wins
        wr_lo = 1'b1; wr_data = 32'hBEEF;
        issue(2'b01, 32'd4, 32'd5);
        wr_lo = 1'b0;
        check("start_wr busy", {63'b0, busy}, 64'd1);
        check("start_wr lo_kept", {32'b0, lo}, 64'd6);
        wait_done("start_wr", 33, 1'b1);
        check_hilo("start_wr", 32'h0, 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
